instr_fetch: RTL and testbench



---
 rtl/riscv_pkg.sv | 15 +
 rtl/instr_fetch_if.sv | 33 +++
 rtl/if_id_reg.sv | 47 ++++
 rtl/instr_fetch.sv | 98 +++++++++
 tb/tb_instr_fetch.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared constants and fetch state encoding
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR_C      = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH_REQ  = 2'd0,
        FETCH_WAIT = 2'd1,
        FETCH_OUT  = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/instr_fetch_if.sv
// rtl/instr_fetch_if.sv - fetch stage memory, redirect and decode-side signals
interface instr_fetch_if
    import riscv_pkg::*;
();
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_addr;
    logic            imem_rsp_valid;
    logic [XLEN-1:0] imem_rsp_data;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            if_valid;
    logic            if_ready;
    logic [XLEN-1:0] if_instr;
    logic [XLEN-1:0] if_pc;
    logic [XLEN-1:0] if_pc_plus4;

    modport master (
        output imem_req_valid, imem_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  redirect_valid, redirect_pc,
        output if_valid, if_instr, if_pc, if_pc_plus4,
        input  if_ready
    );

    modport slave (
        input  imem_req_valid, imem_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output redirect_valid, redirect_pc,
        input  if_valid, if_instr, if_pc, if_pc_plus4,
        output if_ready
    );
endinterface

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - fetch-to-decode output register with load/clear/flush
module if_id_reg
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_C
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_load,
    input  logic            i_clear,
    input  logic            i_flush,
    input  logic [XLEN-1:0] i_instr,
    input  logic [XLEN-1:0] i_pc,
    output logic            o_valid,
    output logic [XLEN-1:0] o_instr,
    output logic [XLEN-1:0] o_pc,
    output logic [XLEN-1:0] o_pc_plus4
);
    logic            r_valid;
    logic [XLEN-1:0] r_instr;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_pc_plus4;

    // Clear/flush leave the PC fields alone; only the instruction is replaced by a NOP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid    <= 1'b0;
            r_instr    <= NOP_INSTR;
            r_pc       <= RESET_PC;
            r_pc_plus4 <= RESET_PC + 32'd4;
        end else if (i_flush || i_clear) begin
            r_valid    <= 1'b0;
            r_instr    <= NOP_INSTR;
        end else if (i_load) begin
            r_valid    <= 1'b1;
            r_instr    <= i_instr;
            r_pc       <= i_pc;
            r_pc_plus4 <= i_pc + 32'd4;
        end
    end

    assign o_valid    = r_valid;
    assign o_instr    = r_instr;
    assign o_pc       = r_pc;
    assign o_pc_plus4 = r_pc_plus4;
endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - PC owner and single-outstanding instruction fetch FSM
module instr_fetch
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_C
) (
    input  logic          clk,
    input  logic          rst_n,
    instr_fetch_if.master bus
);
    fetch_state_e    r_state;
    logic [XLEN-1:0] r_pc;
    logic            r_drop;

    logic            w_load;
    logic            w_clear;
    logic            w_flush;
    logic [XLEN-1:0] w_redirect_pc;
    logic            w_redirect_pc_unused;

    assign w_redirect_pc        = {bus.redirect_pc[XLEN-1:2], 2'b00};
    assign w_redirect_pc_unused = &{1'b0, bus.redirect_pc[1:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= FETCH_REQ;
            r_pc    <= RESET_PC;
            r_drop  <= 1'b0;
        end else if (bus.redirect_valid) begin
            r_pc <= w_redirect_pc;
            case (r_state)
                FETCH_REQ: begin
                    // Old address already accepted: its response must be thrown away.
                    if (bus.imem_req_ready) begin
                        r_state <= FETCH_WAIT;
                        r_drop  <= 1'b1;
                    end
                end
                FETCH_WAIT: begin
                    if (bus.imem_rsp_valid) begin
                        r_state <= FETCH_REQ;
                        r_drop  <= 1'b0;
                    end else begin
                        r_drop  <= 1'b1;
                    end
                end
                FETCH_OUT: r_state <= FETCH_REQ;
                default:   r_state <= FETCH_REQ;
            endcase
        end else begin
            case (r_state)
                FETCH_REQ: begin
                    if (bus.imem_req_ready) r_state <= FETCH_WAIT;
                end
                FETCH_WAIT: begin
                    if (bus.imem_rsp_valid) begin
                        if (r_drop) begin
                            r_drop  <= 1'b0;
                            r_state <= FETCH_REQ;
                        end else begin
                            r_pc    <= r_pc + 32'd4;
                            r_state <= FETCH_OUT;
                        end
                    end
                end
                FETCH_OUT: begin
                    if (bus.if_ready) r_state <= FETCH_REQ;
                end
                default: r_state <= FETCH_REQ;
            endcase
        end
    end

    assign w_load  = (r_state == FETCH_WAIT) && bus.imem_rsp_valid && !r_drop && !bus.redirect_valid;
    assign w_clear = (r_state == FETCH_OUT) && bus.if_ready;
    assign w_flush = (r_state == FETCH_OUT) && bus.redirect_valid;

    assign bus.imem_req_valid = (r_state == FETCH_REQ);
    assign bus.imem_addr      = r_pc;

    if_id_reg #(
        .RESET_PC  (RESET_PC),
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_load),
        .i_clear    (w_clear),
        .i_flush    (w_flush),
        .i_instr    (bus.imem_rsp_data),
        .i_pc       (r_pc),
        .o_valid    (bus.if_valid),
        .o_instr    (bus.if_instr),
        .o_pc       (bus.if_pc),
        .o_pc_plus4 (bus.if_pc_plus4)
    );
endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - scoreboard bench for instr_fetch
module tb_instr_fetch;
    import riscv_pkg::*;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    instr_fetch_if bus ();

    instr_fetch #(
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (32'h0000_0013)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int   tests = 0;
    int   fails = 0;
    exp_t sb[$];

    function automatic void check(input string name, input logic [31:0] got, input logic [31:0] req);
        tests++;
        if (got !== req) begin
            fails++;
            $display("FAIL %s: got %h required %h", name, got, req);
        end
    endfunction

    // Instruction memory model: responds on negedge, lat cycles after acceptance.
    logic        mem_ready = 1'b1;
    int          lat = 1;
    logic        ovr = 1'b0;
    logic        inj = 1'b0;
    logic        pend = 1'b0;
    int          cnt = 0;
    logic [31:0] paddr = '0;

    function automatic logic [31:0] data_of(input logic [31:0] a);
        if (ovr) return 32'hDEAD_BEEF;
        if (a == 32'h0) return 32'h0050_0093;
        return a ^ 32'hA000_0000;
    endfunction

    assign bus.imem_req_ready = mem_ready;

    initial begin
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
    end

    always @(negedge clk) begin
        bus.imem_rsp_valid = 1'b0;
        if (!rst_n) begin
            pend = 1'b0;
        end else begin
            if (inj) begin
                bus.imem_rsp_valid = 1'b1;
                bus.imem_rsp_data  = 32'hBAD0_BAD0;
                inj = 1'b0;
            end
            if (pend) begin
                cnt--;
                if (cnt == 0) begin
                    bus.imem_rsp_valid = 1'b1;
                    bus.imem_rsp_data  = data_of(paddr);
                    pend = 1'b0;
                end
            end
            if (bus.imem_req_valid && mem_ready) begin
                pend  = 1'b1;
                cnt   = lat;
                paddr = bus.imem_addr;
            end
        end
    end

    // Monitor: pops the scoreboard on every decode handshake that is not squashed.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (bus.if_valid && bus.if_ready && !bus.redirect_valid) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_out: got pc=%h instr=%h required none", bus.if_pc, bus.if_instr);
                end else begin
                    e = sb.pop_front();
                    check("out_instr", bus.if_instr, e.instr);
                    check("out_pc", bus.if_pc, e.pc);
                    check("out_pc_plus4", bus.if_pc_plus4, e.pc + 32'd4);
                end
            end
            if (!bus.if_valid) check("idle_nop", bus.if_instr, 32'h0000_0013);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input int budget, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!bus.if_valid && n < budget);
        check("wait_valid", {31'b0, bus.if_valid}, 32'd1);
    endtask

    task automatic push(input logic [31:0] instr, input logic [31:0] pc);
        exp_t e;
        e.instr = instr;
        e.pc    = pc;
        sb.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1);
    end

    initial begin
        int n;
        bus.if_ready       = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        repeat (3) step();

        check("rst_if_valid", {31'b0, bus.if_valid}, 32'd0);
        check("rst_if_instr", bus.if_instr, 32'h0000_0013);
        check("rst_if_pc", bus.if_pc, 32'h0);
        check("rst_if_pc_plus4", bus.if_pc_plus4, 32'h4);
        check("rst_req_valid", {31'b0, bus.imem_req_valid}, 32'd1);

        // First fetch, then hold it under decode backpressure.
        push(32'h0050_0093, 32'h0);
        step();
        rst_n = 1'b1;
        check("first_addr", bus.imem_addr, 32'h0);
        wait_valid(10, n);
        check("first_latency", n, 2);
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_req_valid", {31'b0, bus.imem_req_valid}, 32'd0);
            check("bp_if_instr", bus.if_instr, 32'h0050_0093);
            check("bp_if_pc", bus.if_pc, 32'h0);
        end

        // Sequential fetch with decode always ready: one instruction per 3 cycles.
        bus.if_ready = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            push(32'h0000_0004 * k ^ 32'hA000_0000, 32'h4 * k);
            step();
            check("seq_addr", bus.imem_addr, 32'h4 * k);
            check("seq_req_valid", {31'b0, bus.imem_req_valid}, 32'd1);
            wait_valid(10, n);
            check("seq_gap", n + 1, 3);
        end

        // Redirect while waiting; the stale response arrives later and is dropped.
        lat = 2;
        ovr = 1'b1;
        step();
        check("rdw_addr_0x10", bus.imem_addr, 32'h10);
        step();
        check("rdw_in_wait", {31'b0, bus.imem_req_valid}, 32'd0);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_0100;
        step();
        bus.redirect_valid = 1'b0;
        check("rdw_still_wait", {31'b0, bus.imem_req_valid}, 32'd0);
        check("rdw_no_valid0", {31'b0, bus.if_valid}, 32'd0);
        step();
        check("rdw_req_valid", {31'b0, bus.imem_req_valid}, 32'd1);
        check("rdw_addr", bus.imem_addr, 32'h100);
        check("rdw_no_valid1", {31'b0, bus.if_valid}, 32'd0);
        ovr = 1'b0;
        lat = 1;

        // Misaligned redirect in OUT with simultaneous if_ready squashes the instruction.
        bus.if_ready = 1'b0;
        wait_valid(10, n);
        check("sq_instr_held", bus.if_instr, 32'hA000_0100);
        bus.if_ready       = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_0203;
        step();
        bus.redirect_valid = 1'b0;
        check("sq_if_valid", {31'b0, bus.if_valid}, 32'd0);
        check("sq_if_instr", bus.if_instr, 32'h0000_0013);
        check("sq_addr", bus.imem_addr, 32'h200);
        check("sq_req_valid", {31'b0, bus.imem_req_valid}, 32'd1);

        // Reset mid-WAIT, then a stray response before the next request is accepted.
        lat = 3;
        step();
        check("rst_mid_in_wait", {31'b0, bus.imem_req_valid}, 32'd0);
        rst_n = 1'b0;
        #1;
        check("rst_mid_addr", bus.imem_addr, 32'h0);
        check("rst_mid_req_valid", {31'b0, bus.imem_req_valid}, 32'd1);
        check("rst_mid_if_valid", {31'b0, bus.if_valid}, 32'd0);
        check("rst_mid_if_pc_plus4", bus.if_pc_plus4, 32'h4);
        step();
        rst_n     = 1'b1;
        mem_ready = 1'b0;
        lat       = 1;
        inj       = 1'b1;
        step();
        step();
        check("stray_req_valid", {31'b0, bus.imem_req_valid}, 32'd1);
        check("stray_addr", bus.imem_addr, 32'h0);
        check("stray_if_valid", {31'b0, bus.if_valid}, 32'd0);

        // PC wrap-around from the last word of the address space.
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hFFFF_FFFC;
        step();
        bus.redirect_valid = 1'b0;
        mem_ready          = 1'b1;
        check("wrap_addr", bus.imem_addr, 32'hFFFF_FFFC);
        push(32'h5FFF_FFFC, 32'hFFFF_FFFC);
        wait_valid(10, n);
        step();
        check("wrap_next_addr", bus.imem_addr, 32'h0);
        check("wrap_req_valid", {31'b0, bus.imem_req_valid}, 32'd1);

        step();
        check("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
